// File: rtl/da_fir_serial_if.sv
// Handshake and result bundle for the bit-serial distributed-arithmetic FIR.
// The source drives the master side and the filter sits on the slave side.
interface da_fir_serial_if #(
    parameter int unsigned W_IN  = 4,
    parameter int unsigned W_OUT = 11,
    parameter int unsigned W_LUT = 7
);
    logic              in_valid;
    logic              in_ready;
    logic [W_IN-1:0]   x_in;
    logic              y_valid;
    logic [W_OUT-1:0]  y;
    logic [W_LUT-1:0]  lut;
    logic              busy;

    modport master (output in_valid, x_in,
                    input  in_ready, y_valid, y, lut, busy);
    modport slave  (input  in_valid, x_in,
                    output in_ready, y_valid, y, lut, busy);
endinterface

// File: rtl/da_fir_serial.sv
// Bit-serial distributed-arithmetic FIR without a lookup table: the partial-product
// sum of the current bit-slice is formed by a combinational coefficient adder.
module da_fir_serial #(
    parameter int unsigned              TAPS   = 4,
    parameter int unsigned              W_IN   = 4,
    parameter int unsigned              W_COEF = 5,
    parameter logic [TAPS*W_COEF-1:0]   COEF   = {5'd3, 5'd12, 5'd12, 5'd3},
    parameter bit                       SIGNED = 1'b0,
    parameter int unsigned              W_OUT  = 11
) (
    input  logic           clk,
    input  logic           reset,
    da_fir_serial_if.slave bus
);
    localparam int unsigned TAP_W = $clog2(TAPS);
    localparam int unsigned LUT_W = W_COEF + TAP_W;
    localparam int unsigned ACC_W = W_IN + W_COEF + TAP_W + 1;
    localparam int unsigned CNT_W = $clog2(W_IN);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_nxt;
    logic [W_IN-1:0]    taps   [TAPS];
    logic [W_IN-1:0]    shadow [TAPS];
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   count;
    logic [W_OUT-1:0]   y_q;
    logic               y_valid_q;

    logic               in_ready_c, busy_c, accept_c, shift_c, done_c, last_c;
    logic [LUT_W-1:0]   coef_ext [TAPS];
    logic [LUT_W-1:0]   lut_c;
    logic [ACC_W-1:0]   lut_ext_c, term_c;

    // Coefficients widened once to the adder width (sign-extended in signed mode)
    for (genvar j = 0; j < TAPS; j++) begin : g_coef
        localparam logic [W_COEF-1:0] C = COEF[j*W_COEF +: W_COEF];
        assign coef_ext[j] = {{TAP_W{SIGNED & C[W_COEF-1]}}, C};
    end

    assign last_c = (count == CNT_W'(W_IN - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = SHIFT;
            SHIFT:   if (last_c)       state_nxt = DONE;
            DONE:                      state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = 1'b0;
        busy_c     = 1'b0;
        accept_c   = 1'b0;
        shift_c    = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                accept_c   = bus.in_valid;
            end
            SHIFT: begin
                busy_c  = 1'b1;
                shift_c = 1'b1;
            end
            DONE: begin
                busy_c = 1'b1;
                done_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Coefficient adder over the current LSB of every shadow copy
    always_comb begin
        lut_c = '0;
        for (int j = 0; j < int'(TAPS); j++) begin
            if (shadow[j][0]) lut_c = lut_c + coef_ext[j];
        end
    end

    assign lut_ext_c = {{(ACC_W-LUT_W){SIGNED & lut_c[LUT_W-1]}}, lut_c};
    assign term_c    = lut_ext_c << count;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < int'(TAPS); j++) begin
                taps[j]   <= '0;
                shadow[j] <= '0;
            end
            acc       <= '0;
            count     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            if (accept_c) begin
                taps[0]   <= bus.x_in;
                shadow[0] <= bus.x_in;
                for (int j = 1; j < int'(TAPS); j++) begin
                    taps[j]   <= taps[j-1];
                    shadow[j] <= taps[j-1];
                end
                acc   <= '0;
                count <= '0;
            end
            if (shift_c) begin
                // The sign bit of a two's-complement sample carries negative weight
                acc <= (SIGNED && last_c) ? acc - term_c : acc + term_c;
                for (int j = 0; j < int'(TAPS); j++) shadow[j] <= shadow[j] >> 1;
                count <= count + CNT_W'(1);
            end
            if (done_c) begin
                y_q       <= SIGNED ? W_OUT'($signed(acc)) : W_OUT'(acc);
                y_valid_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.busy     = busy_c;
    assign bus.lut      = lut_c;
    assign bus.y        = y_q;
    assign bus.y_valid  = y_valid_q;
endmodule
